// File: rtl/usb_reset_sequencer.sv
// usb_reset_sequencer
//   Avalon-MM slave that drives the active-low hardware reset of the USB chip.
//   It produces a timed reset pulse followed by a recovery hold-off, reports
//   BUSY/READY/DONE to the driver and raises a level interrupt on completion.
//   Software can also hold the chip in reset indefinitely with FORCE.
//
// Ports
//   clk         system clock
//   reset_n     asynchronous active-low reset
//   address     Avalon word address (0 CONTROL, 1 STATUS, 2 PULSE_LEN, 3 RECOVER_LEN)
//   chipselect  Avalon chip select
//   write_n     Avalon active-low write strobe
//   writedata   Avalon write data
//   readdata    Avalon read data, combinational from address
//   usb_rst_n   registered active-low reset to the USB chip
//   irq         registered level interrupt, DONE & IRQ_EN
//
// state     | meaning
// ----------+-----------------------------------------------------
// S_IDLE    | no sequence running; usb_rst_n low only while FORCE
// S_ASSERT  | usb_rst_n held low, counting down the pulse length
// S_RECOVER | usb_rst_n released, counting down the recovery wait
module usb_reset_sequencer #(
  parameter int              CNT_W           = 16,
  parameter logic [CNT_W-1:0] PULSE_DEFAULT   = CNT_W'(5000),
  parameter logic [CNT_W-1:0] RECOVER_DEFAULT = CNT_W'(5000),
  parameter bit              AUTO_START      = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        usb_rst_n,
  output logic        irq
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ASSERT  = 2'd1,
    S_RECOVER = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] pulse_len_q, recover_len_q;
  logic             force_q, irq_en_q, done_q, ever_done_q;

  logic             wr, wr_ctrl, wr_stat;
  logic             force_d, force_fall, start_req;
  logic             done_set, done_clr, cnt_term;
  logic [CNT_W-1:0] pulse_load;
  logic             busy, ready;
  logic             unused_wd;

  assign wr      = chipselect & ~write_n;
  assign wr_ctrl = wr & (address == 2'd0);
  assign wr_stat = wr & (address == 2'd1);

  // Every CONTROL write rewrites FORCE; START is refused if FORCE is
  // already held or is being raised by the same write.
  assign force_d    = wr_ctrl ? writedata[1] : force_q;
  assign force_fall = force_q & ~force_d;
  assign start_req  = wr_ctrl & writedata[0] & ~writedata[1] & ~force_q;
  assign done_clr   = wr_stat & writedata[2];

  // Terminal compare uses <= 1 so a zero load can never wrap the counter.
  assign cnt_term   = (cnt_q <= CNT_W'(1));
  assign pulse_load = (pulse_len_q == '0) ? CNT_W'(1) : pulse_len_q;

  assign busy  = (state_q != S_IDLE);
  assign ready = ~busy & ~force_q & ever_done_q;

  assign unused_wd = ^writedata[31:CNT_W];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    done_set = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (force_fall) begin
          if (recover_len_q == '0) begin
            done_set = 1'b1;
          end else begin
            state_d = S_RECOVER;
            cnt_d   = recover_len_q;
          end
        end else if (start_req) begin
          state_d = S_ASSERT;
          cnt_d   = pulse_load;
        end
      end
      S_ASSERT: begin
        if (cnt_term) begin
          if (recover_len_q == '0) begin
            state_d  = S_IDLE;
            done_set = 1'b1;
          end else begin
            state_d = S_RECOVER;
            cnt_d   = recover_len_q;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_RECOVER: begin
        if (cnt_term) begin
          state_d  = S_IDLE;
          done_set = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    // FORCE overrides everything: abort to IDLE without completing.
    if (force_d) begin
      state_d  = S_IDLE;
      done_set = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= AUTO_START ? S_ASSERT : S_IDLE;
      cnt_q         <= PULSE_DEFAULT;
      pulse_len_q   <= PULSE_DEFAULT;
      recover_len_q <= RECOVER_DEFAULT;
      force_q       <= 1'b0;
      irq_en_q      <= 1'b0;
      done_q        <= 1'b0;
      ever_done_q   <= 1'b0;
      usb_rst_n     <= !AUTO_START;
      irq           <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      force_q     <= force_d;
      // Set wins over a simultaneous clear.
      done_q      <= done_set | (done_q & ~done_clr);
      ever_done_q <= ever_done_q | done_set;
      usb_rst_n   <= ~((state_d == S_ASSERT) | force_d);
      irq         <= done_q & irq_en_q;
      if (wr_ctrl) irq_en_q <= writedata[2];
      if (wr && address == 2'd2) pulse_len_q   <= writedata[CNT_W-1:0];
      if (wr && address == 2'd3) recover_len_q <= writedata[CNT_W-1:0];
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      2'd0:    readdata[2:1]       = {irq_en_q, force_q};
      2'd1:    readdata[2:0]       = {done_q, ready, busy};
      2'd2:    readdata[CNT_W-1:0] = pulse_len_q;
      default: readdata[CNT_W-1:0] = recover_len_q;
    endcase
  end

endmodule

// File: tb/tb_usb_reset_sequencer.sv
`timescale 1ns/1ps
module tb_usb_reset_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata_a, readdata_b;
  logic        usb_rst_n_a, usb_rst_n_b;
  logic        irq_a, irq_b;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // instance 0: auto-start with 5000/5000; instance 1: idle after reset with 7/9
  localparam int PDEF [2] = '{5000, 7};
  localparam int RDEF [2] = '{5000, 9};
  localparam bit AUTO [2] = '{1'b1, 1'b0};

  usb_reset_sequencer #(.CNT_W(16), .PULSE_DEFAULT(16'd5000), .RECOVER_DEFAULT(16'd5000),
                        .AUTO_START(1'b1)) dut_a (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata_a),
    .usb_rst_n(usb_rst_n_a), .irq(irq_a));

  usb_reset_sequencer #(.CNT_W(16), .PULSE_DEFAULT(16'd7), .RECOVER_DEFAULT(16'd9),
                        .AUTO_START(1'b0)) dut_b (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata_b),
    .usb_rst_n(usb_rst_n_b), .irq(irq_b));

  always #5 clk = ~clk;

  // Timeline model: a sequence is described by the cycle at which the pulse
  // ends (low_end) and the cycle at which it completes (end_c, -1 until the
  // recovery length has been sampled at pulse end).
  int          cyc;
  bit          m_active [2];
  int          m_low_end [2];
  int          m_end [2];
  bit          m_force [2], m_irq_en [2], m_done [2], m_ever [2], m_irq [2];
  logic [15:0] m_plen [2], m_rlen [2];

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cyc = 0;
      for (int i = 0; i < 2; i++) begin
        m_force[i] = 0; m_irq_en[i] = 0; m_done[i] = 0; m_ever[i] = 0; m_irq[i] = 0;
        m_plen[i] = 16'(PDEF[i]); m_rlen[i] = 16'(RDEF[i]);
        m_active[i] = AUTO[i];
        m_low_end[i] = (PDEF[i] > 1) ? PDEF[i] : 1;
        m_end[i] = -1;
      end
    end else begin
      bit wr;
      cyc++;
      wr = chipselect && !write_n;
      for (int i = 0; i < 2; i++) begin
        bit new_force, dset, was_active;
        dset = 0;
        was_active = m_active[i];
        new_force = (wr && address == 2'd0) ? writedata[1] : m_force[i];
        if (new_force) begin
          m_active[i] = 0;
        end else if (was_active) begin
          if (m_end[i] == -1 && cyc == m_low_end[i]) m_end[i] = cyc + int'(m_rlen[i]);
          if (m_end[i] == cyc) begin m_active[i] = 0; dset = 1; end
        end else if (m_force[i]) begin
          m_active[i] = 1; m_low_end[i] = cyc; m_end[i] = cyc + int'(m_rlen[i]);
          if (m_end[i] == cyc) begin m_active[i] = 0; dset = 1; end
        end else if (wr && address == 2'd0 && writedata[0]) begin
          m_active[i] = 1;
          m_low_end[i] = cyc + ((m_plen[i] == 0) ? 1 : int'(m_plen[i]));
          m_end[i] = -1;
        end
        m_irq[i] = m_done[i] & m_irq_en[i];
        m_done[i] = dset | (m_done[i] & !(wr && address == 2'd1 && writedata[2]));
        m_ever[i] = m_ever[i] | dset;
        if (wr && address == 2'd0) begin m_irq_en[i] = writedata[2]; m_force[i] = new_force; end
        if (wr && address == 2'd2) m_plen[i] = writedata[15:0];
        if (wr && address == 2'd3) m_rlen[i] = writedata[15:0];
      end
    end
  end

  function automatic logic exp_usb(int i);
    return !(m_force[i] || (m_active[i] && cyc < m_low_end[i]));
  endfunction

  function automatic logic [31:0] exp_rd(int i, logic [1:0] a);
    logic [31:0] r;
    r = '0;
    case (a)
      2'd0: r[2:1] = {m_irq_en[i], m_force[i]};
      2'd1: r[2:0] = {m_done[i], !m_active[i] && !m_force[i] && m_ever[i], m_active[i]};
      2'd2: r[15:0] = m_plen[i];
      default: r[15:0] = m_rlen[i];
    endcase
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("usb_rst_n_a", {31'b0, usb_rst_n_a}, {31'b0, exp_usb(0)});
      chk("usb_rst_n_b", {31'b0, usb_rst_n_b}, {31'b0, exp_usb(1)});
      chk("irq_a", {31'b0, irq_a}, {31'b0, m_irq[0]});
      chk("irq_b", {31'b0, irq_b}, {31'b0, m_irq[1]});
      chk("readdata_a", readdata_a, exp_rd(0, address));
      chk("readdata_b", readdata_b, exp_rd(1, address));
    end
  end

  int run_b = 0, last_run_b = 0, runs_b = 0;
  always @(negedge clk) begin
    if (!reset_n) run_b = 0;
    else if (!usb_rst_n_b) run_b++;
    else if (run_b != 0) begin last_run_b = run_b; runs_b++; run_b = 0; end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Drive one write; it is sampled at the second posedge. Bus parks on STATUS.
  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    @(posedge clk); #2;
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    @(posedge clk); #2;
    chipselect = 1'b0; write_n = 1'b1; address = 2'd1; writedata = '0;
  endtask

  initial begin
    int n, runs0;
    logic [31:0] lit_a [4];
    logic [31:0] lit_b [4];
    lit_a = '{32'd0, 32'd1, 32'd5000, 32'd5000};
    lit_b = '{32'd0, 32'd0, 32'd7, 32'd9};
    reset_n = 1'b0; chipselect = 1'b0; write_n = 1'b1; address = 2'd1; writedata = '0;
    @(posedge clk); #2;
    chk_en = 1'b1;
    wait_cycles(2);
    chk("reset_usb_a", {31'b0, usb_rst_n_a}, 32'd0);
    chk("reset_usb_b", {31'b0, usb_rst_n_b}, 32'd1);
    reset_n = 1'b1;

    // 1: auto-start pulse and recovery with default lengths
    n = 0;
    for (int g = 0; g < 6000; g++) begin
      @(negedge clk);
      if (usb_rst_n_a) break;
      n++;
    end
    chk("t1_pulse_len", n, 32'd5000);
    n = 0;
    for (int g = 0; g < 6000; g++) begin
      if (readdata_a[2]) break;
      @(negedge clk);
      n++;
    end
    chk("t1_done_delay", n, 32'd5000);
    chk("t1_ready", {31'b0, readdata_a[1]}, 32'd1);
    chk("t1_irq", {31'b0, irq_a}, 32'd0);
    chk("t1_b_idle", readdata_b[2:0], 32'd0);

    // 2: 3-cycle pulse, no recovery, interrupt enabled
    bus_write(2'd2, 32'd3);
    bus_write(2'd3, 32'd0);
    bus_write(2'd0, 32'h5);
    n = 0;
    for (int g = 0; g < 50; g++) begin
      @(negedge clk);
      if (usb_rst_n_b) break;
      n++;
    end
    chk("t2_pulse_len", n, 32'd3);
    chk("t2_done_on_release", {31'b0, readdata_b[2]}, 32'd1);
    chk("t2_model_done", {31'b0, m_done[1]}, 32'd1);
    chk("t2_irq_not_yet", {31'b0, irq_b}, 32'd0);
    @(negedge clk);
    chk("t2_irq_set", {31'b0, irq_b}, 32'd1);
    bus_write(2'd1, 32'h4);
    @(negedge clk);
    @(negedge clk);
    chk("t2_irq_cleared", {31'b0, irq_b}, 32'd0);
    chk("t2_done_cleared", {31'b0, readdata_b[2]}, 32'd0);

    // 3: START during ASSERT is ignored; PULSE_LEN=0 gives 1-cycle pulse
    bus_write(2'd2, 32'd6);
    bus_write(2'd3, 32'd2);
    runs0 = runs_b;
    bus_write(2'd0, 32'h1);
    bus_write(2'd0, 32'h1);
    wait_cycles(20);
    chk("t3_pulse_unchanged", last_run_b, 32'd6);
    chk("t3_single_sequence", runs_b - runs0, 32'd1);
    bus_write(2'd2, 32'd0);
    bus_write(2'd0, 32'h1);
    wait_cycles(10);
    chk("t3_min_pulse", last_run_b, 32'd1);

    // 4: FORCE mid-RECOVER aborts; releasing FORCE runs a 4-cycle recovery
    bus_write(2'd1, 32'h4);
    bus_write(2'd2, 32'd2);
    bus_write(2'd3, 32'd10);
    bus_write(2'd0, 32'h1);
    wait_cycles(4);
    bus_write(2'd0, 32'h2);
    @(negedge clk);
    chk("t4_force_low", {31'b0, usb_rst_n_b}, 32'd0);
    chk("t4_abort_status", readdata_b[2:0], 32'd0);
    wait_cycles(3);
    bus_write(2'd3, 32'd4);
    bus_write(2'd0, 32'h0);
    n = 0;
    for (int g = 0; g < 30; g++) begin
      @(negedge clk);
      if (!readdata_b[0]) break;
      n++;
    end
    chk("t4_busy_cycles", n, 32'd4);
    chk("t4_done", {31'b0, readdata_b[2]}, 32'd1);
    chk("t4_released", {31'b0, usb_rst_n_b}, 32'd1);

    // 6: DONE-clear in the completion cycle loses to the set
    bus_write(2'd1, 32'h4);
    bus_write(2'd2, 32'd2);
    bus_write(2'd3, 32'd3);
    bus_write(2'd0, 32'h1);
    wait_cycles(3);
    bus_write(2'd1, 32'h4);
    @(negedge clk);
    chk("t6_done_set_wins", {31'b0, readdata_b[2]}, 32'd1);

    // 5: asynchronous reset in the middle of ASSERT
    bus_write(2'd2, 32'd20);
    bus_write(2'd3, 32'd5);
    bus_write(2'd0, 32'h5);
    wait_cycles(2);
    reset_n = 1'b0;
    #1;
    chk("t5_usb_a", {31'b0, usb_rst_n_a}, 32'd0);
    chk("t5_usb_b", {31'b0, usb_rst_n_b}, 32'd1);
    chk("t5_irq_a", {31'b0, irq_a}, 32'd0);
    chk("t5_irq_b", {31'b0, irq_b}, 32'd0);
    for (int a = 0; a < 4; a++) begin
      @(posedge clk); #2;
      address = 2'(a);
      #1;
      chk($sformatf("t5_read_a_%0d", a), readdata_a, lit_a[a]);
      chk($sformatf("t5_read_b_%0d", a), readdata_b, lit_b[a]);
    end
    @(posedge clk); #2;
    address = 2'd1;
    reset_n = 1'b1;
    wait_cycles(3);
    chk("t5_autostart_again", {31'b0, usb_rst_n_a}, 32'd0);
    chk("t5_b_stays_idle", readdata_b[2:0], 32'd0);

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
